// File: rtl/ring_johnson_counter_if.sv
// Control and status bundle for the ring/Johnson sequencer.
// The master steers the counter; the slave owns the registered state.
interface ring_johnson_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] result;
    logic             wrap;
    logic             err;

    modport master (
        output en, mode, dir, load, load_val,
        input  result, wrap, err
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output result, wrap, err
    );
endinterface

// File: rtl/ring_johnson_counter.sv
// One-hot ring or Johnson counter, bidirectional, with load,
// self-correction of illegal states, and wrap/err pulses.
module ring_johnson_counter #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    ring_johnson_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] HOME = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("ring_johnson_counter: WIDTH must be >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_inv;
    logic [WIDTH-1:0] nxt;
    logic             ring_ok;
    logic             john_ok;
    logic             legal;

    assign q     = bus.result;
    assign q_inv = ~q;

    // x & (x+1) == 0 holds exactly for x = 2^k - 1 (LSB-anchored run).
    assign ring_ok = (q != '0) && ((q & (q - ONE)) == '0);
    assign john_ok = ((q & (q + ONE)) == '0) ||
                     ((q_inv & (q_inv + ONE)) == '0);
    assign legal   = bus.mode ? john_ok : ring_ok;

    always_comb begin
        nxt = q;
        case ({bus.mode, bus.dir})
            2'b00:   nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            2'b01:   nxt = {q[0], q[WIDTH-1:1]};
            2'b10:   nxt = {q[WIDTH-2:0], ~q[WIDTH-1]};
            2'b11:   nxt = {~q[0], q[WIDTH-1:1]};
            default: nxt = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.result <= HOME;
            bus.wrap   <= 1'b0;
            bus.err    <= 1'b0;
        end else if (bus.load) begin
            bus.result <= bus.load_val;
            bus.wrap   <= 1'b0;
            bus.err    <= 1'b0;
        end else if (bus.en) begin
            if (!legal) begin
                bus.result <= HOME;
                bus.wrap   <= 1'b0;
                bus.err    <= 1'b1;
            end else begin
                bus.result <= nxt;
                bus.wrap   <= (nxt == HOME);
                bus.err    <= 1'b0;
            end
        end else begin
            bus.wrap <= 1'b0;
            bus.err  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed bench for ring_johnson_counter at WIDTH = 4.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_ring_johnson_counter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    ring_johnson_counter_if #(.WIDTH(4)) bus ();

    ring_johnson_counter #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_check(input string tag,
                              input logic [3:0] r,
                              input logic w,
                              input logic e);
        step();
        check({tag, ".result"}, 32'(bus.result), 32'(r));
        check({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
        check({tag, ".err"}, 32'(bus.err), 32'(e));
    endtask

    task automatic drive(input logic en, input logic mode,
                         input logic dir, input logic load,
                         input logic [3:0] val);
        bus.en       = en;
        bus.mode     = mode;
        bus.dir      = dir;
        bus.load     = load;
        bus.load_val = val;
    endtask

    logic [3:0] ring_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] ring_r [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] john_l [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                               4'b1100, 4'b1000, 4'b0000, 4'b0001};
    logic [3:0] john_r [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                               4'b1111, 4'b0111, 4'b0011, 4'b0001};

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        step();
        step();
        check("reset.result", 32'(bus.result), 32'h1);
        check("reset.wrap", 32'(bus.wrap), 32'h0);
        check("reset.err", 32'(bus.err), 32'h0);
        rst = 1'b0;
        step_check("idle", 4'b0001, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++)
            step_check("ring_l", ring_l[i], i == 3, 1'b0);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++)
            step_check("ring_r", ring_r[i], i == 3, 1'b0);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 8; i++)
            step_check("john_l", john_l[i], i == 7, 1'b0);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 8; i++)
            step_check("john_r", john_r[i], i == 7, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
        step_check("ld_0110", 4'b0110, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step_check("fix_ring", 4'b0001, 1'b0, 1'b1);
        step_check("after_fix", 4'b0010, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1100);
        step_check("ld_1100", 4'b1100, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        step_check("john_1100", 4'b1000, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0101);
        step_check("ld_0101", 4'b0101, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        step_check("fix_john", 4'b0001, 1'b0, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
        step_check("ld_0010", 4'b0010, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        step_check("mode_sw", 4'b0001, 1'b0, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++)
            step_check("hold", 4'b0001, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100);
        step_check("prio", 4'b0100, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
        step_check("ld_home", 4'b0001, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
        step_check("ld_1000", 4'b1000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1 rst = 1'b1;
        #1;
        check("async.result", 32'(bus.result), 32'h1);
        check("async.wrap", 32'(bus.wrap), 32'h0);
        check("async.err", 32'(bus.err), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        check("rst_hold", 32'(bus.result), 32'h1);
        rst = 1'b0;
        step_check("resume", 4'b0010, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_johnson_counter.md
Name: ring_johnson_counter

Overview:
Parametrised successor to the team's N-bit ring counter. It runs as either a one-hot ring counter or a Johnson (twisted-ring) counter, selectable at run time, and can shift in either direction. It adds enable, synchronous parallel load, self-correction of illegal states, a wrap pulse and an error pulse. It is used as a sequencer or phase generator wherever a one-hot or thermometer-style step pattern is needed.

Parameters:
WIDTH, 4, counter width in bits; legal range WIDTH >= 2 (elaboration-time check required)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  step enable; one step per clk edge while high
mode  input  1  0 = ring (one-hot), 1 = Johnson (twisted ring)
dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right)
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value captured on load
result  output  WIDTH  counter state (registered)
wrap  output  1  one-cycle pulse: a normal step has just returned result to the home state
err  output  1  one-cycle pulse: an illegal state has just been corrected

Behaviour:
- Home state HOME = {WIDTH-1 zeros, 1}, i.e. 0...01.
- Reset:
  - rst high forces result = HOME, wrap = 0, err = 0 immediately, without waiting for clk.
  - The outputs hold these values for as long as rst is high.
  - The first step after rst falls occurs on the first clk edge with en = 1.
- Priority per edge when rst is low: load > en > hold.
- Load (load = 1):
  - result <= load_val verbatim, with no legality check.
  - wrap <= 0, err <= 0.
  - en is ignored on that cycle.
- Hold (load = 0, en = 0):
  - result is unchanged, wrap <= 0, err <= 0.
- Step (load = 0, en = 1): the legality check uses the current state and the current mode.
  - Ring legal: result has exactly one bit set.
  - Johnson legal: result equals (2^k)-1 or ~((2^k)-1) for some k in 0..WIDTH, i.e. a contiguous run of ones anchored at the LSB or at the MSB. All-zero and all-one are legal.
  - Illegal state: result <= HOME, err <= 1, wrap <= 0.
  - Legal state: next value is computed as follows, then err <= 0.
    - ring, dir = 0: {q[W-2:0], q[W-1]}
    - ring, dir = 1: {q[0], q[W-1:1]}
    - Johnson, dir = 0: {q[W-2:0], ~q[W-1]}
    - Johnson, dir = 1: {~q[0], q[W-1:1]}
  - wrap <= 1 only when a legal step produces HOME. A corrected state or a loaded HOME never raises wrap.
- Cycle lengths: ring has period WIDTH; Johnson has period 2*WIDTH. Both directions pass through HOME.
- Changing mode or dir mid-sequence:
  - Takes effect on the next step; no flush is performed.
  - If the state is illegal for the new mode, the next step corrects it (err pulse).
  - Example: ring state 0010 under Johnson is illegal and becomes 0001 with err = 1.
- wrap and err are mutually exclusive and are never high together.
- There are no combinational paths from inputs to outputs.

Test Plan:
- Ring, left, WIDTH = 4:
  - Stimulus: reset, then en = 1, mode = 0, dir = 0.
  - Required: result 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - wrap = 1 only on the cycle result returns to 0001 (4th step); err stays 0.
- Ring, right:
  - Stimulus: mode = 0, dir = 1, from 0001.
  - Required: 1000 -> 0100 -> 0010 -> 0001, with wrap on the 4th step.
- Johnson, left:
  - Stimulus: mode = 1, dir = 0, from 0001.
  - Required: 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001, with wrap only on the 8th step.
  - Repeat with dir = 1; required: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
- Load and correction:
  - Ring mode: load 0110, then en = 1 -> result 0001, err = 1, wrap = 0; the next step gives 0010 with err = 0.
  - Johnson mode: load 1100, then step -> 1000 with no err.
  - Johnson mode: load 0101, then step -> 0001 with err = 1.
- Priority and hold:
  - Stimulus: en = 0 for 3 cycles.
  - Required: result frozen, wrap = 0, err = 0.
  - Stimulus: load = 1 and en = 1 together with load_val = 0100.
  - Required: result = 0100, with no step applied that cycle.
- Asynchronous reset:
  - Stimulus: assert rst between clk edges while result = 1000.
  - Required: result = 0001 before the next edge; wrap = 0, err = 0; the counter resumes from 0001 once rst is released.
